sprite_blitter: RTL
===================

# sprite_blitter

Write-source client of the frame manager's source-arbitration handshake. When the manager selects this block's source ID and raises `write_awaited`, the block claims the write bus and streams one sprite into the back framebuffer. It fetches texels from an external synchronous sprite ROM and clips them against the draw area. It then releases the bus so the manager can advance to the next source or swap frames.

## Interface
Parameters:
- `SOURCE_ID`, default 0: value of `write_source_sel` that selects this block.
- `SPRITE_W`, default 32: sprite width in draw pixels; multiple of `SCALE_DOWN_FACTOR`.
- `SPRITE_H`, default 32: sprite height in draw pixels; multiple of `SCALE_DOWN_FACTOR`.
- `SCALE_DOWN_FACTOR`, default 2: coordinate step in x and y; power of 2; equals the frame manager's factor.
- `TRANSPARENT_COLOR`, default 0: texel value that is never written.

Ports:
- `clk`  in  1  clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `write_awaited`  in  1  manager requests a write pass.
- `write_source_sel`  in  `SOURCE_SEL_ADDRW`  currently selected source.
- `pos_x`  in  `DRAW_WIDTH_ADDRW+1`  signed sprite left edge.
- `pos_y`  in  `DRAW_HEIGHT_ADDRW+1`  signed sprite top edge.
- `visible`  in  1  0 = complete the handshake without drawing.
- `rom_addr`  out  `$clog2(SPRITE_W*SPRITE_H)`  texel address, `sy*SPRITE_W+sx`.
- `rom_data`  in  `COLOR_DEPTH`  texel; valid 1 cycle after `rom_addr`.
- `write_active`  out  1  bus claim; every high cycle is one write.
- `write_transparent`  out  1  suppress this write.
- `write_color_data`  out  `COLOR_DEPTH`  pixel color.
- `write_x_addr`  out  `DRAW_WIDTH_ADDRW`  pixel x.
- `write_y_addr`  out  `DRAW_HEIGHT_ADDRW`  pixel y.

## Operation
- FSM states are IDLE, FETCH, STREAM, DRAIN and RELEASE.
- **IDLE**
  - Trigger condition: `write_awaited && write_source_sel==SOURCE_ID`.
  - On trigger, latch `pos_x`, `pos_y` and `visible`, then go to FETCH. Later changes to these inputs are ignored until the next trigger.
  - If `write_source_sel` does not match, ignore `write_awaited`.
- **FETCH**: present `rom_addr`=0; `write_active`=0. Go to STREAM.
- **STREAM**
  - Each cycle, issue the next texel address; the sprite walks raster order, stepping `sx` and `sy` by `SCALE_DOWN_FACTOR`.
  - Drive the previous texel, via output registers, with `write_active`=1.
  - After the last address is issued, go to DRAIN.
- **DRAIN**: emit the final pixel, then go to RELEASE.
- **RELEASE**
  - `write_active`=0; all write outputs are 0.
  - Wait until `write_awaited`==0, then return to IDLE. This prevents re-triggering on the manager's stale `write_awaited`.
- Write count N = (`SPRITE_W`/F)·(`SPRITE_H`/F); `write_active` is high for exactly N consecutive cycles with no gaps.
- `write_transparent`=1 when `rom_data`==`TRANSPARENT_COLOR`.
- Invisible pass (latched `visible`=0): skip FETCH and STREAM; hold `write_active`=1 with `write_transparent`=1 for exactly 1 cycle, then go to RELEASE. The manager must always see `write_active` so it cannot deadlock.
- Coordinate arithmetic:
  - Pixel x = `pos_x+sx`, computed at `DRAW_WIDTH_ADDRW+2` bits signed; y likewise.
  - Outputs carry the low bits.
- Whenever `write_active`=0, all write outputs are 0, so the manager can OR or mux the source buses.

## Timing
- Reset: all outputs 0, `rom_addr`=0, state IDLE; this is asynchronous and takes effect mid-blit.
- Trigger sampled at edge T: `rom_addr`=0 during cycle T+1; first write cycle is T+3; `write_active` falls at edge T+3+N.
- ROM-to-bus latency: 2 cycles (ROM read plus output register).
- Invisible pass: `write_active` is high during cycle T+1 only.
- Back-to-back passes: the earliest re-trigger is the first edge after `write_awaited` is sampled low and then high again.

## Configuration
- `SPRITE_BLITTER_CLIP_EN` defined:
  - Any pixel with x<0, x≥`DRAW_WIDTH`, y<0 or y≥`DRAW_HEIGHT` is forced to `write_transparent`=1.
  - The cycle count is unchanged.
- Undefined:
  - No clipping; coordinates wrap modulo the address width.
  - The caller must keep the sprite fully on-screen.

## Structure
- The shared package (the frame-manager header contents) holds `COLOR_DEPTH`, `DRAW_WIDTH`, `DRAW_HEIGHT`, `DRAW_WIDTH_ADDRW`, `DRAW_HEIGHT_ADDRW`, `SOURCE_SEL_ADDRW`, and the blitter state enum typedef.
- One sub-module: `blit_scan_counter`. It generates the sx/sy raster walk, the ROM address and the last-texel flag.

## Test plan
- 32×32 sprite, F=2, `pos`=(10,20), trigger → `write_active` high for 256 consecutive cycles. First write is (10,20) with texel 0; the last is (40,50) with texel 990.
- Texel 5 == `TRANSPARENT_COLOR` → the matching write cycle has `write_transparent`=1; cycle count is still 256.
- `visible`=0 → exactly one `write_active` cycle with `write_transparent`=1, then RELEASE.
- `write_source_sel`=SOURCE_ID+1 with `write_awaited`=1 → outputs stay 0 and no ROM walk starts.
- `SPRITE_BLITTER_CLIP_EN`, `pos`=(−4,0) → writes with x<0 are transparent; total cycles are unchanged.
- `resetN` pulsed low at write 100 → all outputs 0 immediately, state IDLE; the next trigger restarts at texel 0.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// sprite_blitter_pkg
// Shared frame-manager definitions used by the sprite blitter: color depth,
// draw-area geometry and address widths, source-select width, and the
// blitter state encoding.
package sprite_blitter_pkg;

  localparam int COLOR_DEPTH       = 8;
  localparam int DRAW_WIDTH        = 320;
  localparam int DRAW_HEIGHT       = 240;
  localparam int DRAW_WIDTH_ADDRW  = 9;
  localparam int DRAW_HEIGHT_ADDRW = 8;
  localparam int SOURCE_SEL_ADDRW  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_DRAIN,
    ST_RELEASE
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_scan_counter.sv
// blit_scan_counter
// Raster walk over the sprite texture in steps of F in both x and y.
// Keeps sx, sy and the linear ROM address (sy*W + sx) as registers so the
// address is a clean registered output; flags the final texel.
// Ports:
//   clk, resetN   clock, asynchronous active-low reset
//   i_clear       return to texel (0,0)
//   i_step        advance to the next texel in raster order
//   o_sx, o_sy    current texel coordinates
//   o_addr        current ROM address
//   o_last        current texel is the last one of the sprite
module blit_scan_counter #(
  parameter int W   = 32,
  parameter int H   = 32,
  parameter int F   = 2,
  parameter int AW  = 10,
  parameter int SXW = 5,
  parameter int SYW = 5
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           i_clear,
  input  logic           i_step,
  output logic [SXW-1:0] o_sx,
  output logic [SYW-1:0] o_sy,
  output logic [AW-1:0]  o_addr,
  output logic           o_last
);

  logic [SXW-1:0] r_sx;
  logic [SYW-1:0] r_sy;
  logic [AW-1:0]  r_addr;
  logic           w_row_end;

  assign w_row_end = (r_sx == SXW'(W - F));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_addr <= '0;
    end else if (i_clear) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_addr <= '0;
    end else if (i_step) begin
      if (w_row_end) begin
        r_sx   <= '0;
        r_sy   <= r_sy + SYW'(F);
        // From (sy, W-F) to (sy+F, 0): +F*W - (W-F)
        r_addr <= r_addr + AW'((F - 1) * W + F);
      end else begin
        r_sx   <= r_sx + SXW'(F);
        r_addr <= r_addr + AW'(F);
      end
    end
  end

  assign o_sx   = r_sx;
  assign o_sy   = r_sy;
  assign o_addr = r_addr;
  assign o_last = w_row_end && (r_sy == SYW'(H - F));

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter
// Write-source client of the frame manager's source arbitration. When the
// manager selects SOURCE_ID and raises write_awaited, the blitter latches the
// sprite position, walks the sprite ROM and streams one write per texel onto
// the write bus, then releases the bus and waits for write_awaited to drop.
// Build option: define SPRITE_BLITTER_CLIP_EN to mark off-screen pixels as
// transparent; otherwise coordinates wrap and the caller keeps the sprite
// on-screen.
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   write_awaited          manager requests a write pass
//   write_source_sel       currently selected source
//   pos_x, pos_y           signed sprite top-left corner
//   visible                0 = handshake only, no drawing
//   rom_addr / rom_data    synchronous sprite ROM (1-cycle read)
//   write_active           bus claim, one write per high cycle
//   write_transparent      suppress this write
//   write_color_data       pixel color
//   write_x_addr/y_addr    pixel coordinates
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int SOURCE_ID         = 0,
  parameter int SPRITE_W          = 32,
  parameter int SPRITE_H          = 32,
  parameter int SCALE_DOWN_FACTOR = 2,
  parameter int TRANSPARENT_COLOR = 0
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  write_awaited,
  input  logic [SOURCE_SEL_ADDRW-1:0]           write_source_sel,
  input  logic [DRAW_WIDTH_ADDRW:0]             pos_x,
  input  logic [DRAW_HEIGHT_ADDRW:0]            pos_y,
  input  logic                                  visible,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  rom_addr,
  input  logic [COLOR_DEPTH-1:0]                rom_data,
  output logic                                  write_active,
  output logic                                  write_transparent,
  output logic [COLOR_DEPTH-1:0]                write_color_data,
  output logic [DRAW_WIDTH_ADDRW-1:0]           write_x_addr,
  output logic [DRAW_HEIGHT_ADDRW-1:0]          write_y_addr
);

  localparam int ROM_AW = $clog2(SPRITE_W * SPRITE_H);
  localparam int SXW    = $clog2(SPRITE_W);
  localparam int SYW    = $clog2(SPRITE_H);
  localparam int XW     = DRAW_WIDTH_ADDRW;
  localparam int YW     = DRAW_HEIGHT_ADDRW;

  blit_state_t r_state;

  logic [XW:0]             r_pos_x;
  logic [YW:0]             r_pos_y;
  logic                    r_d1_vld;   // rom_data holds a texel this cycle
  logic [SXW-1:0]          r_d1_sx;
  logic [SYW-1:0]          r_d1_sy;
  logic                    r_write_active;
  logic                    r_write_transparent;
  logic [COLOR_DEPTH-1:0]  r_write_color;
  logic [XW-1:0]           r_write_x;
  logic [YW-1:0]           r_write_y;

  logic                    w_trigger;
  logic                    w_issue;
  logic                    w_cnt_clear;
  logic                    w_cnt_step;
  logic [SXW-1:0]          w_sx;
  logic [SYW-1:0]          w_sy;
  logic [ROM_AW-1:0]       w_addr;
  logic                    w_last;
  logic [XW+1:0]           w_px;
  logic [YW+1:0]           w_py;
  logic                    w_clip;
  logic                    w_texel_transparent;

  assign w_trigger   = write_awaited &&
                       (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));
  assign w_issue     = (r_state == ST_FETCH) || (r_state == ST_STREAM);
  assign w_cnt_clear = (r_state == ST_IDLE);
  // Hold on the last texel so the address is stable through DRAIN
  assign w_cnt_step  = w_issue && !w_last;

  blit_scan_counter #(
    .W   (SPRITE_W),
    .H   (SPRITE_H),
    .F   (SCALE_DOWN_FACTOR),
    .AW  (ROM_AW),
    .SXW (SXW),
    .SYW (SYW)
  ) u_scan (
    .clk     (clk),
    .resetN  (resetN),
    .i_clear (w_cnt_clear),
    .i_step  (w_cnt_step),
    .o_sx    (w_sx),
    .o_sy    (w_sy),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  assign rom_addr = w_addr;

  // Sign-extend position by one bit and add the unsigned texel offset so
  // off-screen pixels on either side remain distinguishable.
  assign w_px = {r_pos_x[XW], r_pos_x} + (XW + 2)'(r_d1_sx);
  assign w_py = {r_pos_y[YW], r_pos_y} + (YW + 2)'(r_d1_sy);

  assign w_texel_transparent = (rom_data == COLOR_DEPTH'(TRANSPARENT_COLOR));

`ifdef SPRITE_BLITTER_CLIP_EN
  assign w_clip = w_px[XW+1] || (w_px >= (XW + 2)'(DRAW_WIDTH)) ||
                  w_py[YW+1] || (w_py >= (YW + 2)'(DRAW_HEIGHT));
`else
  // Coordinates wrap; the extension bits only matter when clipping.
  logic w_unused_ext;
  assign w_unused_ext = ^{w_px[XW+1:XW], w_py[YW+1:YW]};
  assign w_clip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state             <= ST_IDLE;
      r_pos_x             <= '0;
      r_pos_y             <= '0;
      r_d1_vld            <= 1'b0;
      r_d1_sx             <= '0;
      r_d1_sy             <= '0;
      r_write_active      <= 1'b0;
      r_write_transparent <= 1'b0;
      r_write_color       <= '0;
      r_write_x           <= '0;
      r_write_y           <= '0;
    end else begin
      // Coordinates travel alongside the ROM read so they meet rom_data
      r_d1_vld <= w_issue;
      r_d1_sx  <= w_sx;
      r_d1_sy  <= w_sy;

      // Bus is all-zero unless a write is being driven
      r_write_active      <= 1'b0;
      r_write_transparent <= 1'b0;
      r_write_color       <= '0;
      r_write_x           <= '0;
      r_write_y           <= '0;
      if (r_d1_vld) begin
        r_write_active      <= 1'b1;
        r_write_transparent <= w_texel_transparent || w_clip;
        r_write_color       <= rom_data;
        r_write_x           <= w_px[XW-1:0];
        r_write_y           <= w_py[YW-1:0];
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_pos_x <= pos_x;
            r_pos_y <= pos_y;
            if (visible) begin
              r_state <= ST_FETCH;
            end else begin
              // Single transparent write keeps the manager's handshake moving
              r_write_active      <= 1'b1;
              r_write_transparent <= 1'b1;
              r_state             <= ST_RELEASE;
            end
          end
        end
        ST_FETCH:   r_state <= w_last ? ST_DRAIN : ST_STREAM;
        ST_STREAM:  if (w_last) r_state <= ST_DRAIN;
        ST_DRAIN:   r_state <= ST_RELEASE;
        ST_RELEASE: if (!write_awaited) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign write_active      = r_write_active;
  assign write_transparent = r_write_transparent;
  assign write_color_data  = r_write_color;
  assign write_x_addr      = r_write_x;
  assign write_y_addr      = r_write_y;

endmodule
